// File: rtl/clk_en_ctrl.sv
// clk_en_ctrl: activity-driven power-enable controller for one clock domain.
// It gates the domain after IDLE_CYCLES consecutive idle cycles and
// re-enables it on new activity. awake rises WAKE_CYCLES edges after pwr_en.
// Every output is registered.
//
// Optional build macro CLK_EN_CTRL_STATS_EN adds the gated_cycles and
// wake_count statistics counters. When the macro is undefined, both outputs
// are tied to zero.
module clk_en_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        activity,
  input  logic        dbg_override,
  output logic        pwr_en,
  output logic        gating_override,
  output logic        awake,
  output logic [1:0]  state,
  output logic [31:0] gated_cycles,
  output logic [15:0] wake_count
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKING = 2'd2
  } state_t;

  // Terminal counts. The idle and wake counters both count up from zero.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] r_wake_cnt;
  logic [CNT_W-1:0] w_idle_cnt_nxt;
  logic [CNT_W-1:0] w_wake_cnt_nxt;
  logic             r_pwr_en;
  logic             r_awake;
  logic             r_gating_override;
  logic             w_pwr_en_nxt;
  logic             w_awake_nxt;

  // State register plus the registered outputs and counters. Reset wins.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_ACTIVE;
      r_idle_cnt        <= '0;
      r_wake_cnt        <= '0;
      r_pwr_en          <= 1'b1;
      r_awake           <= 1'b1;
      r_gating_override <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_idle_cnt        <= w_idle_cnt_nxt;
      r_wake_cnt        <= w_wake_cnt_nxt;
      r_pwr_en          <= w_pwr_en_nxt;
      r_awake           <= w_awake_nxt;
      r_gating_override <= dbg_override;
    end
  end

  // Next state and next counter values. dbg_override beats activity and the
  // idle timeout. The illegal encoding 3 falls back to ACTIVE.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = '0;
    w_wake_cnt_nxt = r_wake_cnt;
    if (dbg_override) begin
      w_state_nxt = ST_ACTIVE;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (!activity) begin
            if (r_idle_cnt == IDLE_LAST) begin
              w_state_nxt = ST_GATED;
            end else begin
              w_idle_cnt_nxt = r_idle_cnt + 1'b1;
            end
          end
        end
        ST_GATED: begin
          if (activity) begin
            w_state_nxt    = ST_WAKING;
            w_wake_cnt_nxt = '0;
          end
        end
        ST_WAKING: begin
          // activity is ignored while the clock is coming back up
          w_wake_cnt_nxt = r_wake_cnt + 1'b1;
          if (r_wake_cnt == WAKE_LAST) begin
            w_state_nxt = ST_ACTIVE;
          end
        end
        default: begin
          w_state_nxt = ST_ACTIVE;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs line up
  // with the registered state.
  always_comb begin
    w_pwr_en_nxt = (w_state_nxt != ST_GATED);
    w_awake_nxt  = (w_state_nxt == ST_ACTIVE);
  end

  assign pwr_en          = r_pwr_en;
  assign awake           = r_awake;
  assign gating_override = r_gating_override;
  assign state           = r_state;

`ifdef CLK_EN_CTRL_STATS_EN
  logic [31:0] r_gated_cycles;
  logic [15:0] r_wake_count;
  logic        w_wake_evt;

  // A wake is counted only on a real GATED->WAKING transition.
  // An override exit is not a wake.
  assign w_wake_evt = (r_state == ST_GATED) && activity && !dbg_override;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gated_cycles <= '0;
      r_wake_count   <= '0;
    end else begin
      if ((r_state == ST_GATED) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
        r_gated_cycles <= r_gated_cycles + 32'd1;
      end
      if (w_wake_evt && (r_wake_count != 16'hFFFF)) begin
        r_wake_count <= r_wake_count + 16'd1;
      end
    end
  end

  assign gated_cycles = r_gated_cycles;
  assign wake_count   = r_wake_count;
`else
  assign gated_cycles = '0;
  assign wake_count   = '0;
`endif

endmodule

// File: tb/tb_clk_en_ctrl.sv
// tb_clk_en_ctrl: scoreboard bench for clk_en_ctrl with IDLE_CYCLES=4 and
// WAKE_CYCLES=2.
// Each scenario task builds a plan of {reset, dbg_override, activity} steps,
// each paired with the outputs expected after that edge. Driving a step
// pushes its expectation onto the scoreboard. The task pops the entry and
// compares it once the DUT has produced its post-edge outputs.
// Counter expectations fall to zero when CLK_EN_CTRL_STATS_EN is undefined.
module tb_clk_en_ctrl;

`ifdef CLK_EN_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        activity = 1'b0;
  logic        dbg_override = 1'b0;
  logic        pwr_en;
  logic        gating_override;
  logic        awake;
  logic [1:0]  state;
  logic [31:0] gated_cycles;
  logic [15:0] wake_count;

  clk_en_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_W      (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .activity       (activity),
    .dbg_override   (dbg_override),
    .pwr_en         (pwr_en),
    .gating_override(gating_override),
    .awake          (awake),
    .state          (state),
    .gated_cycles   (gated_cycles),
    .wake_count     (wake_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        pe;
    logic        aw;
    logic        go;
    logic [31:0] gc;
    logic [15:0] wc;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] plan_s[$];
  exp_t       plan_x[$];
  int         n_cmp = 0;
  int         n_mis = 0;

  // Builds an expected record. The counters read zero without the stats build.
  function automatic exp_t mk(input int st, input bit pe, input bit aw,
                              input bit go, input int gc, input int wc);
    exp_t e;
    e.st = 2'(st);
    e.pe = pe;
    e.aw = aw;
    e.go = go;
    e.gc = STATS ? 32'(gc) : 32'd0;
    e.wc = STATS ? 16'(wc) : 16'd0;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.st = state;
    e.pe = pwr_en;
    e.aw = awake;
    e.go = gating_override;
    e.gc = gated_cycles;
    e.wc = wake_count;
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("st=%0d pe=%0b aw=%0b go=%0b gc=%0d wc=%0d",
                     e.st, e.pe, e.aw, e.go, e.gc, e.wc);
  endfunction

  // Appends one step (reset, override, activity) and its post-edge expectation.
  function automatic void add(input bit r, input bit o, input bit a, input exp_t e);
    plan_s.push_back({r, o, a});
    plan_x.push_back(e);
  endfunction

  // Applies one step, records its expectation, and settles 1 ns past the edge.
  task automatic drive(input logic [2:0] s, input exp_t e);
    {reset, dbg_override, activity} = s;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dbg_override = 1'b0;
    activity = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reset beats override and activity. gating_override follows one edge later.
  task automatic test_reset();
    exp_t got, want;
    int i = 0;
    add(1, 1, 1, mk(0, 1, 1, 0, 0, 0));
    add(1, 1, 1, mk(0, 1, 1, 0, 0, 0));
    add(0, 1, 1, mk(0, 1, 1, 1, 0, 0));
    add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front(), plan_x.pop_front());
      got = obs();
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL reset step %0d: got %s want %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Gating on the 4th idle edge. Activity on the 4th idle cycle restarts the count.
  task automatic test_idle_timeout();
    exp_t got, want;
    int i = 0;
    do_reset();
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 1, 0));
    add(1, 0, 0, mk(0, 1, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 1, mk(0, 1, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front(), plan_x.pop_front());
      got = obs();
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL idle_timeout step %0d: got %s want %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Wake timing, with extra activity during WAKING, then back-to-back gating.
  task automatic test_wake();
    exp_t got, want;
    int i = 0;
    do_reset();
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    add(0, 0, 1, mk(2, 1, 0, 0, 1, 1));
    add(0, 0, 1, mk(2, 1, 0, 0, 1, 1));
    add(0, 0, 1, mk(0, 1, 1, 0, 1, 1));
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 1, 1));
    add(0, 0, 0, mk(1, 0, 0, 0, 1, 1));
    add(0, 0, 1, mk(2, 1, 0, 0, 2, 2));
    add(0, 0, 0, mk(2, 1, 0, 0, 2, 2));
    add(0, 0, 0, mk(0, 1, 1, 0, 2, 2));
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front(), plan_x.pop_front());
      got = obs();
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL wake step %0d: got %s want %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Override exits GATED and WAKING without counting a wake, blocks gating,
  // and beats activity.
  task automatic test_override();
    exp_t got, want;
    int i = 0;
    do_reset();
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    add(0, 1, 0, mk(0, 1, 1, 1, 1, 0));
    for (int k = 0; k < 10; k++) add(0, 1, 0, mk(0, 1, 1, 1, 1, 0));
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 1, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 1, 0));
    add(0, 0, 1, mk(2, 1, 0, 0, 2, 1));
    add(0, 1, 0, mk(0, 1, 1, 1, 2, 1));
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 2, 1));
    add(0, 0, 0, mk(1, 0, 0, 0, 2, 1));
    add(0, 1, 1, mk(0, 1, 1, 1, 3, 1));
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front(), plan_x.pop_front());
      got = obs();
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL override step %0d: got %s want %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Seven GATED edges followed by one wake: gated_cycles=7, wake_count=1.
  task automatic test_stats();
    exp_t got, want;
    int i = 0;
    do_reset();
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++) add(0, 0, 0, mk(1, 0, 0, 0, k, 0));
    add(0, 0, 1, mk(2, 1, 0, 0, 7, 1));
    add(0, 0, 0, mk(2, 1, 0, 0, 7, 1));
    add(0, 0, 0, mk(0, 1, 1, 0, 7, 1));
    add(0, 0, 0, mk(0, 1, 1, 0, 7, 1));
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front(), plan_x.pop_front());
      got = obs();
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL stats step %0d: got %s want %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Reset one edge into WAKING. The next gating needs a full 4 idle edges.
  task automatic test_reset_mid_wake();
    exp_t got, want;
    int i = 0;
    do_reset();
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    add(0, 0, 1, mk(2, 1, 0, 0, 1, 1));
    add(1, 0, 0, mk(0, 1, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) add(0, 0, 0, mk(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front(), plan_x.pop_front());
      got = obs();
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL reset_mid_wake step %0d: got %s want %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_timeout();
    test_wake();
    test_override();
    test_stats();
    test_reset_mid_wake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clk_en_ctrl.md
Name: clk_en_ctrl

Overview:
- Activity-driven power-enable controller, directly upstream of the clock gate.
- Produces the pwr_en and gating_override inputs that the gate for one clock domain consumes.
- Gates the domain after a programmable run of idle cycles and re-enables it on new activity.
- Raises awake once the wake latency has elapsed.

Parameters:
- IDLE_CYCLES, 16: consecutive idle cycles before gating. Legal range 1..2^CNT_W-1.
- WAKE_CYCLES, 2: cycles from pwr_en rising to awake asserting. Legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the internal idle and wake counters.

Ports:
- clk  in  1  free-running clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- activity  in  1  domain has work this cycle.
- dbg_override  in  1  debug/test request to keep the clock running.
- pwr_en  out  1  power enable to the clock gate.
- gating_override  out  1  registered copy of dbg_override, sent to the clock gate.
- awake  out  1  domain clock is stable; upstream may issue work.
- state  out  2  FSM state: 0=ACTIVE, 1=GATED, 2=WAKING.
- gated_cycles  out  32  statistics: cycles spent in GATED (see Optional Feature).
- wake_count  out  16  statistics: number of GATED->WAKING transitions.

Behaviour:
- All outputs are registered.
- Reset values: state=ACTIVE, pwr_en=1, awake=1, gating_override=0, gated_cycles=0, wake_count=0. Internal idle_cnt=0, wake_cnt=0.
- Reset has priority over every other input. Reset during any state returns to ACTIVE on the next edge.
- gating_override <= dbg_override every cycle, giving 1-cycle latency.
- ACTIVE state:
  - activity=1: idle_cnt <= 0.
  - activity=0 and idle_cnt < IDLE_CYCLES-1: idle_cnt increments.
  - activity=0 and idle_cnt == IDLE_CYCLES-1: next state GATED, pwr_en <= 0, awake <= 0, idle_cnt <= 0.
  - Result: pwr_en falls on the edge that samples the IDLE_CYCLES-th consecutive idle cycle.
- GATED state:
  - pwr_en=0, awake=0.
  - activity=1: next state WAKING, pwr_en <= 1, wake_cnt <= 0, wake_count increments.
  - activity=0: stay in GATED.
- WAKING state:
  - pwr_en=1, awake=0. activity is ignored; upstream must hold or retry its work.
  - wake_cnt increments each cycle.
  - When wake_cnt == WAKE_CYCLES-1: next state ACTIVE, awake <= 1, idle_cnt <= 0.
  - Result: awake rises exactly WAKE_CYCLES edges after pwr_en rises.
- Override:
  - While dbg_override=1 (sampled), the next state is forced to ACTIVE with pwr_en <= 1, awake <= 1, idle_cnt <= 0.
  - This applies from any state, abandons WAKING early, and does not increment wake_count.
  - Gating cannot occur while dbg_override=1.
- Simultaneous events:
  - reset beats dbg_override.
  - dbg_override beats activity and the idle timeout.
  - In ACTIVE, activity=1 on the timeout cycle clears idle_cnt; no gating occurs.
- Counters:
  - gated_cycles increments on each edge where the current state is GATED.
  - gated_cycles saturates at 32'hFFFF_FFFF and wake_count saturates at 16'hFFFF. Neither wraps.
- state encoding 3 is unreachable. If it is ever entered, the next state is ACTIVE.

Optional Feature:
- Macro: CLK_EN_CTRL_STATS_EN.
- Defined: gated_cycles and wake_count are implemented as described in Behaviour.
- Undefined: neither counter register exists; gated_cycles and wake_count are tied to 0. FSM, pwr_en, awake and gating_override are unchanged.

Test Plan:
All scenarios use IDLE_CYCLES=4, WAKE_CYCLES=2 and CLK_EN_CTRL_STATS_EN defined unless stated.
- Reset: hold reset 2 cycles with activity=1 and dbg_override=1 -> during and after reset pwr_en=1, awake=1, state=0, gating_override=0 (becomes 1 one edge after release), counters 0.
- Idle timeout: after reset, activity=0 continuously -> pwr_en=0, awake=0, state=1 after the 4th edge. Repeat with activity=1 on the 4th idle cycle -> state remains 0 and pwr_en stays 1.
- Wake: in GATED, pulse activity=1 for 1 cycle -> pwr_en=1 and state=2 on the next edge, awake=1 and state=0 two edges later. Extra activity pulses during WAKING do not change timing.
- Override: in GATED, set dbg_override=1 -> next edge: state=0, pwr_en=1, awake=1, gating_override=1, wake_count unchanged. Hold override with activity=0 for 10 cycles -> no gating. Release -> gating 4 edges later.
- Statistics: gate, hold GATED 7 cycles, wake -> gated_cycles=7, wake_count=1. Rebuild without CLK_EN_CTRL_STATS_EN -> both read 0 and FSM timing is identical.
- Reset mid-wake: assert reset on the edge after entering WAKING -> state=0, pwr_en=1, awake=1, counters 0. Next gating takes a full 4 idle cycles.
